pc_sequencer: RTL and testbench

Parametrised program-counter sequencer. It replaces the fixed-width "pc plus one" incrementer. It holds the architectural PC and picks the next PC each `step` edge from trap, redirect, return-address-stack pop, stall hold, or sequential increment. It sits at the front of the pipeline and drives the fetch address. It also keeps a small circular return-address stack (RAS) and an exception PC.

---
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next fetch PC from trap, redirect, RAS pop,
// stall hold or sequential increment, and keeps a circular return-address stack.
module pc_sequencer #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] INC       = WIDTH'(1),
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [63:0]     TRAP_VEC  = 64'h0000_0010,
  parameter int              RAS_DEPTH = 4
) (
  input  logic             step,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             call,
  input  logic             ret,
  input  logic             trap,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow,
  output logic             ras_overflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] TRAP_PC = TRAP_VEC[WIDTH-1:0];
  localparam logic [CW-1:0]    FULL_COUNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             underflow_q, underflow_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [PW-1:0]    top_idx;
  logic             push;

  // ptr_q points at the next free slot; the top entry sits one below it.
  assign pc_inc    = pc_q + INC;
  assign top_idx   = ptr_q - PW'(1);
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == FULL_COUNT);

  always_comb begin
    pc_d        = pc_q;
    epc_d       = epc_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    push        = 1'b0;
    underflow_d = 1'b0;
    overflow_d  = 1'b0;
    if (trap) begin
      pc_d  = TRAP_PC;
      epc_d = pc_q;
    end else if (redirect_valid) begin
      pc_d = redirect_target;
      if (call) begin
        push  = 1'b1;
        ptr_d = ptr_q + PW'(1);
        // A full stack wraps onto its oldest entry; depth stays saturated.
        if (ras_full) overflow_d = 1'b1;
        else          count_d    = count_q + CW'(1);
      end
    end else if (!stall) begin
      if (ret) begin
        if (ras_empty) begin
          pc_d        = pc_inc;
          underflow_d = 1'b1;
        end else begin
          pc_d    = ras_q[top_idx];
          ptr_d   = top_idx;
          count_d = count_q - CW'(1);
        end
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge step or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_VEC;
      epc_q       <= '0;
      ptr_q       <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        if (push && (ptr_q == PW'(i))) ras_q[i] <= pc_inc;
      end
    end
  end

  assign pc            = pc_q;
  assign epc           = epc_q;
  assign ras_underflow = underflow_q;
  assign ras_overflow  = overflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed plan followed by random traffic, all checked
// against a queue-based behavioural model of the PC and return-address stack.
module tb_pc_sequencer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] TRAP  = 32'h0000_0010;
  localparam logic [31:0] RVEC  = 32'h0;

  logic        step = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] pc, epc;
  logic        ras_empty, ras_full, ras_underflow, ras_overflow;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras[$];
  logic        m_uf, m_of;

  pc_sequencer dut (
    .step(step), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .call(call), .ret(ret), .trap(trap),
    .pc(pc), .epc(epc), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_underflow(ras_underflow), .ras_overflow(ras_overflow)
  );

  always #5 step = ~step;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = RVEC;
    m_epc = 32'h0;
    m_ras.delete();
    m_uf  = 1'b0;
    m_of  = 1'b0;
  endtask

  task automatic model_step(input bit t, rv, c, r, s, input logic [31:0] tgt);
    m_uf = 1'b0;
    m_of = 1'b0;
    if (t) begin
      m_epc = m_pc;
      m_pc  = TRAP;
    end else if (rv) begin
      if (c) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_of = 1'b1;
        end
        m_ras.push_back(m_pc + 32'd1);
      end
      m_pc = tgt;
    end else if (s) begin
      // held
    end else if (r) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc = m_pc + 32'd1;
        m_uf = 1'b1;
      end
    end else begin
      m_pc = m_pc + 32'd1;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".pc"}, pc, m_pc);
    chk({ctx, ".epc"}, epc, m_epc);
    chk({ctx, ".empty"}, 32'(ras_empty), 32'(m_ras.size() == 0));
    chk({ctx, ".full"}, 32'(ras_full), 32'(m_ras.size() == DEPTH));
    chk({ctx, ".uf"}, 32'(ras_underflow), 32'(m_uf));
    chk({ctx, ".of"}, 32'(ras_overflow), 32'(m_of));
  endtask

  // One step edge: drive, clock, advance model, sample 1 time unit later.
  task automatic cyc(input string ctx, input bit t, rv, c, r, s, input logic [31:0] tgt);
    trap = t; redirect_valid = rv; call = c; ret = r; stall = s; redirect_target = tgt;
    @(posedge step);
    model_step(t, rv, c, r, s, tgt);
    #1;
    $display("cyc %s trap=%0b rv=%0b call=%0b ret=%0b stall=%0b tgt=%h -> pc=%h epc=%h",
             ctx, t, rv, c, r, s, tgt, pc, epc);
    check_all(ctx);
  endtask

  task automatic mid_reset(input string ctx);
    #2 reset = 1'b1;
    #1;
    model_reset();
    $display("reset %s -> pc=%h", ctx, pc);
    check_all(ctx);
    #1 reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge step);
    #1;
    check_all("por");
    #3 reset = 1'b0;

    // Sequential run to pc=7, then asynchronous reset mid-cycle
    for (int i = 0; i < 7; i++) cyc("seq", 0, 0, 0, 0, 0, '0);
    chk("seq_pc7", pc, 32'h7);
    mid_reset("async");
    chk("async_pc0", pc, 32'h0);
    for (int i = 0; i < 3; i++) cyc("post_rst", 0, 0, 0, 0, 0, '0);
    chk("post_rst_pc3", pc, 32'h3);

    // Wrap-around
    cyc("wrap_set", 0, 1, 0, 0, 0, 32'hFFFF_FFFF);
    cyc("wrap", 0, 0, 0, 0, 0, '0);
    chk("wrap_pc0", pc, 32'h0);

    // Call / ret / underflow
    cyc("go20", 0, 1, 0, 0, 0, 32'h20);
    cyc("call", 0, 1, 1, 0, 0, 32'h100);
    cyc("seq1", 0, 0, 0, 0, 0, '0);
    cyc("seq2", 0, 0, 0, 0, 0, '0);
    chk("pc102", pc, 32'h102);
    cyc("ret", 0, 0, 0, 1, 0, '0);
    chk("ret_pc21", pc, 32'h21);
    cyc("ret_uf", 0, 0, 0, 1, 0, '0);
    chk("uf_pc22", pc, 32'h22);
    cyc("uf_drop", 0, 0, 0, 0, 0, '0);

    // Overflow: five calls, five rets
    cyc("go10", 0, 1, 0, 0, 0, 32'h10);
    for (int i = 2; i <= 6; i++) cyc("ovf_call", 0, 1, 1, 0, 0, 32'(i * 16));
    chk("ovf_full", 32'(ras_full), 32'h1);
    for (int i = 0; i < 5; i++) cyc("ovf_ret", 0, 0, 0, 1, 0, '0);
    chk("ovf_last_pc", pc, 32'h22);

    // Stall vs redirect
    cyc("sv_call", 0, 1, 1, 0, 0, 32'h200);
    cyc("stall_ret", 0, 0, 0, 1, 1, '0);
    cyc("stall_redir", 0, 1, 0, 0, 1, 32'h80);
    chk("stall_redir_pc", pc, 32'h80);

    // Trap priority
    cyc("go44", 0, 1, 0, 0, 0, 32'h44);
    cyc("trap", 1, 1, 1, 1, 1, 32'h300);
    chk("trap_epc", epc, 32'h44);

    // Random traffic with one asynchronous reset
    for (int n = 0; n < 400; n++) begin
      bit t, rv, c, r, s;
      logic [31:0] tgt;
      t   = ($urandom_range(0, 15) == 0);
      rv  = ($urandom_range(0, 3) == 0);
      c   = $urandom_range(0, 1) == 1;
      r   = ($urandom_range(0, 2) == 0);
      s   = ($urandom_range(0, 4) == 0);
      tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      cyc("rand", t, rv, c, r, s, tgt);
      if (n == 200) mid_reset("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
